mmc1_bank_ctrl: RTL

//  MMC1 (mapper 1) bank controller for the cartridge BRAM datapath. Decodes CPU writes to $8000-$FFFF

---
 rtl/mmc1_bank_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/mmc1_bank_ctrl.sv
// rtl/mmc1_bank_ctrl.sv - MMC1 serial-load bank controller driving PRG/CHR BRAM addresses and mirroring
module mmc1_bank_ctrl #(
  parameter int PRG_ADDR_W = 18,
  parameter int CHR_ADDR_W = 17
) (
  input  logic                  clk_cpu,
  input  logic                  rst_n,
  input  logic [14:0]           cpu_addr,
  input  logic [7:0]            cpu_data_i,
  input  logic                  cpu_rw,
  input  logic                  romsel,
  input  logic [13:0]           ppu_addr,
  output logic [PRG_ADDR_W-1:0] prg_addr,
  output logic [CHR_ADDR_W-1:0] chr_addr,
  output logic                  ciram_a10,
  output logic                  ciram_ce,
  output logic                  prgram_ce,
  output logic                  busy
);

  logic [4:0] shift;
  logic [4:0] ctrl;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;
  logic       wr_prev;
  logic       wr;
  logic       accept;
  logic [4:0] val;
  logic [3:0] bank;
  logic [4:0] chr_bank;
  logic       unused_data;

  assign wr          = romsel & ~cpu_rw;
  assign accept      = wr & ~wr_prev;
  assign val         = {cpu_data_i[0], shift[4:1]};
  assign unused_data = ^cpu_data_i[6:1];

  // Only the first write of a back-to-back pair counts, so RMW dummy writes are dropped.
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      shift   <= 5'b10000;
      ctrl    <= 5'h0C;
      chr0    <= 5'h00;
      chr1    <= 5'h00;
      prg     <= 5'h00;
      wr_prev <= 1'b0;
    end else begin
      wr_prev <= wr;
      if (accept) begin
        if (cpu_data_i[7]) begin
          shift <= 5'b10000;
          ctrl  <= ctrl | 5'h0C;
        end else if (!shift[0]) begin
          shift <= val;
        end else begin
          shift <= 5'b10000;
          case (cpu_addr[14:13])
            2'd0:    ctrl <= val;
            2'd1:    chr0 <= val;
            2'd2:    chr1 <= val;
            default: prg  <= val;
          endcase
        end
      end
    end
  end

  always_comb begin
    bank = 4'h0;
    case (ctrl[3:2])
      2'd0, 2'd1: bank = {prg[3:1], cpu_addr[14]};
      2'd2:       bank = cpu_addr[14] ? prg[3:0] : 4'h0;
      default:    bank = cpu_addr[14] ? 4'hF : prg[3:0];
    endcase
  end

  always_comb begin
    chr_bank = ppu_addr[12] ? chr1 : chr0;
    if (ctrl[4]) chr_addr = CHR_ADDR_W'({chr_bank, ppu_addr[11:0]});
    else         chr_addr = CHR_ADDR_W'({chr0[4:1], ppu_addr[12:0]});
  end

  always_comb begin
    ciram_a10 = 1'b0;
    case (ctrl[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_addr[10];
      default: ciram_a10 = ppu_addr[11];
    endcase
  end

  assign prg_addr  = PRG_ADDR_W'({bank, cpu_addr[13:0]});
  assign ciram_ce  = ppu_addr[13];
  assign prgram_ce = ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg[4];
  assign busy      = (shift != 5'b10000);

endmodule
